// File: rtl/alu_unit.sv
// Registered execute-stage ALU: decodes OPCODE, computes a 32-bit result and
// branch-condition flags from Rs-Rt, and forwards the destination tag and opcode.
module alu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  OPCODE,
  input  logic [31:0] Rd,
  input  logic [31:0] Rs,
  input  logic [31:0] Rsi,
  input  logic [31:0] Rt,
  output logic [6:0]  RdOut,
  output logic [6:0]  branchResult,
  output logic [4:0]  OpCode,
  output logic [31:0] AluResult
);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDI = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_SLL  = 5'd7;
  localparam logic [4:0] OP_SRL  = 5'd8;
  localparam logic [4:0] OP_SRA  = 5'd9;
  localparam logic [4:0] OP_SLT  = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd11;
  localparam logic [4:0] OP_BEQ  = 5'd12;
  localparam logic [4:0] OP_BNE  = 5'd13;
  localparam logic [4:0] OP_BLT  = 5'd14;
  localparam logic [4:0] OP_MOV  = 5'd15;

  logic [31:0] alu_result_d, alu_result_q;
  logic [6:0]  branch_result_d, branch_result_q;
  logic [6:0]  rd_out_d, rd_out_q;
  logic [4:0]  op_code_d, op_code_q;

  logic [32:0] diff_ext;
  logic [31:0] diff;
  logic        flag_zero, flag_neg, flag_borrow, flag_ovf, flag_eq, flag_lt, flag_taken;

  // Upper tag bits are architecturally ignored.
  logic unused_rd;
  assign unused_rd = ^Rd[31:7];

  always_comb begin
    diff_ext    = {1'b0, Rs} - {1'b0, Rt};
    diff        = diff_ext[31:0];
    flag_zero   = (diff == 32'd0);
    flag_neg    = diff[31];
    flag_borrow = diff_ext[32];
    flag_ovf    = (Rs[31] != Rt[31]) && (diff[31] != Rs[31]);
    flag_eq     = (Rs == Rt);
    flag_lt     = ($signed(Rs) < $signed(Rt));
    flag_taken  = 1'b0;
    case (OPCODE)
      OP_BEQ:  flag_taken = flag_eq;
      OP_BNE:  flag_taken = !flag_eq;
      OP_BLT:  flag_taken = flag_lt;
      default: flag_taken = 1'b0;
    endcase
  end

  // Each arm touches only the operands it needs, so an unknown Rt cannot
  // leak into ADDI, MOV or NOP results.
  always_comb begin
    alu_result_d = 32'd0;
    case (OPCODE)
      OP_NOP:  alu_result_d = 32'd0;
      OP_ADD:  alu_result_d = Rs + Rt;
      OP_ADDI: alu_result_d = Rs + Rsi;
      OP_SUB:  alu_result_d = diff;
      OP_AND:  alu_result_d = Rs & Rt;
      OP_OR:   alu_result_d = Rs | Rt;
      OP_XOR:  alu_result_d = Rs ^ Rt;
      OP_SLL:  alu_result_d = Rs << Rt[4:0];
      OP_SRL:  alu_result_d = Rs >> Rt[4:0];
      OP_SRA:  alu_result_d = $signed(Rs) >>> Rt[4:0];
      OP_SLT:  alu_result_d = {31'd0, flag_lt};
      OP_MUL:  alu_result_d = Rs * Rt;
      OP_BEQ,
      OP_BNE,
      OP_BLT:  alu_result_d = diff;
      OP_MOV:  alu_result_d = Rsi;
      default: alu_result_d = 32'd0;
    endcase
    branch_result_d = {flag_taken, flag_lt, flag_eq, flag_ovf, flag_borrow, flag_neg, flag_zero};
    rd_out_d        = Rd[6:0];
    op_code_d       = OPCODE;
  end

  // No handshake: a new operation is captured on every rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_q    <= 32'd0;
      branch_result_q <= 7'd0;
      rd_out_q        <= 7'd0;
      op_code_q       <= 5'd0;
    end else begin
      alu_result_q    <= alu_result_d;
      branch_result_q <= branch_result_d;
      rd_out_q        <= rd_out_d;
      op_code_q       <= op_code_d;
    end
  end

  assign AluResult    = alu_result_q;
  assign branchResult = branch_result_q;
  assign RdOut        = rd_out_q;
  assign OpCode       = op_code_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit: reset, arithmetic, flags,
// branches, a back-to-back counting sweep and reserved/passthrough behaviour.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  OPCODE;
  logic [31:0] Rd, Rs, Rsi, Rt;
  logic [6:0]  RdOut, branchResult;
  logic [4:0]  OpCode;
  logic [31:0] AluResult;

  int n_checks = 0;
  int n_fail   = 0;

  alu_unit dut (
    .clk          (clk),
    .rst          (rst),
    .OPCODE       (OPCODE),
    .Rd           (Rd),
    .Rs           (Rs),
    .Rsi          (Rsi),
    .Rt           (Rt),
    .RdOut        (RdOut),
    .branchResult (branchResult),
    .OpCode       (OpCode),
    .AluResult    (AluResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, let it be captured, then sample 1 time unit later.
  task automatic drive_op(input logic [4:0] op, input logic [31:0] rd,
                          input logic [31:0] rs, input logic [31:0] rsi,
                          input logic [31:0] rt);
    OPCODE = op; Rd = rd; Rs = rs; Rsi = rsi; Rt = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_op(5'd1, 32'd33, 32'd5, 32'd0, 32'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (AluResult !== 32'd0 || branchResult !== 7'd0 || RdOut !== 7'd0 || OpCode !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_async: res=%h flags=%h rd=%h op=%h, want all 0",
               AluResult, branchResult, RdOut, OpCode);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (AluResult !== 32'd0 || branchResult !== 7'd0 || RdOut !== 7'd0 || OpCode !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_hold: res=%h flags=%h rd=%h op=%h, want all 0",
               AluResult, branchResult, RdOut, OpCode);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_arith();
    drive_op(5'd1, 32'd1, 32'd5, 32'd7, 32'd3);
    n_checks++;
    if (AluResult !== 32'd8) begin n_fail++; $display("FAIL add: got %h want 8", AluResult); end
    drive_op(5'd2, 32'd1, 32'd5, 32'd7, 32'd3);
    n_checks++;
    if (AluResult !== 32'd12) begin n_fail++; $display("FAIL addi: got %h want c", AluResult); end
    drive_op(5'd3, 32'd1, 32'd5, 32'd7, 32'd3);
    n_checks++;
    if (AluResult !== 32'd2 || branchResult !== 7'h00) begin
      n_fail++; $display("FAIL sub_pos: got %h/%h want 2/00", AluResult, branchResult);
    end
    drive_op(5'd3, 32'd1, 32'd3, 32'd7, 32'd5);
    n_checks++;
    if (AluResult !== 32'hFFFF_FFFE || branchResult !== 7'h26) begin
      n_fail++; $display("FAIL sub_neg: got %h/%h want fffffffe/26", AluResult, branchResult);
    end
    drive_op(5'd11, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd3);
    n_checks++;
    if (AluResult !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL mul: got %h want fffffffd", AluResult); end
    drive_op(5'd10, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
    n_checks++;
    if (AluResult !== 32'd1) begin n_fail++; $display("FAIL slt_neg: got %h want 1", AluResult); end
    drive_op(5'd15, 32'd1, 32'd4, 32'h1234_5678, 32'd9);
    n_checks++;
    if (AluResult !== 32'h1234_5678) begin n_fail++; $display("FAIL mov: got %h want 12345678", AluResult); end
  endtask

  task automatic test_logic();
    drive_op(5'd4, 32'd0, 32'hF0F0_00FF, 32'd0, 32'h0FF0_0F0F);
    n_checks++;
    if (AluResult !== 32'h00F0_000F) begin n_fail++; $display("FAIL and: got %h want 00f0000f", AluResult); end
    drive_op(5'd5, 32'd0, 32'hF0F0_00FF, 32'd0, 32'h0FF0_0F0F);
    n_checks++;
    if (AluResult !== 32'hFFF0_0FFF) begin n_fail++; $display("FAIL or: got %h want fff00fff", AluResult); end
    drive_op(5'd6, 32'd0, 32'hF0F0_00FF, 32'd0, 32'h0FF0_0F0F);
    n_checks++;
    if (AluResult !== 32'hFF00_0FF0) begin n_fail++; $display("FAIL xor: got %h want ff000ff0", AluResult); end
  endtask

  task automatic test_overflow_shift();
    drive_op(5'd3, 32'd0, 32'h8000_0000, 32'd0, 32'd1);
    n_checks++;
    if (AluResult !== 32'h7FFF_FFFF || branchResult !== 7'h28) begin
      n_fail++; $display("FAIL sub_ovf: got %h/%h want 7fffffff/28", AluResult, branchResult);
    end
    drive_op(5'd9, 32'd0, 32'h8000_0000, 32'd0, 32'd4);
    n_checks++;
    if (AluResult !== 32'hF800_0000 || branchResult !== 7'h28) begin
      n_fail++; $display("FAIL sra: got %h/%h want f8000000/28", AluResult, branchResult);
    end
    drive_op(5'd8, 32'd0, 32'h8000_0000, 32'd0, 32'd4);
    n_checks++;
    if (AluResult !== 32'h0800_0000) begin n_fail++; $display("FAIL srl: got %h want 08000000", AluResult); end
  endtask

  task automatic test_branch();
    drive_op(5'd12, 32'd0, 32'd9, 32'd0, 32'd9);
    n_checks++;
    if (branchResult !== 7'h51 || AluResult !== 32'd0) begin
      n_fail++; $display("FAIL beq: got %h/%h want 51/0", branchResult, AluResult);
    end
    drive_op(5'd13, 32'd0, 32'd9, 32'd0, 32'd9);
    n_checks++;
    if (branchResult !== 7'h11) begin n_fail++; $display("FAIL bne: got %h want 11", branchResult); end
    drive_op(5'd14, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    n_checks++;
    if (branchResult !== 7'h62 || AluResult !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL blt: got %h/%h want 62/ffffffff", branchResult, AluResult);
    end
    drive_op(5'd1, 32'd0, 32'd9, 32'd0, 32'd9);
    n_checks++;
    if (branchResult !== 7'h11 || AluResult !== 32'd18) begin
      n_fail++; $display("FAIL add_nobranch: got %h/%h want 11/12", branchResult, AluResult);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    exp_q = '{32'd0, 32'd2, 32'd4, 32'd0, 32'd4, 32'd5, 32'd0, 32'd896, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i <= 10; i++) begin
      drive_op(5'(i), 32'(i), 32'(i), 32'(i), 32'(i));
      exp_v = exp_q.pop_front();
      n_checks++;
      if (AluResult !== exp_v || RdOut !== 7'(i) || OpCode !== 5'(i) || branchResult !== 7'h11) begin
        n_fail++;
        $display("FAIL sweep_%0d: res=%h rd=%h op=%h flags=%h want %h/%h/%h/11",
                 i, AluResult, RdOut, OpCode, branchResult, exp_v, 7'(i), 5'(i));
      end
    end
  endtask

  task automatic test_reserved_passthrough();
    drive_op(5'd31, 32'hFFFF_FF85, 32'd10, 32'd77, 32'd10);
    n_checks++;
    if (AluResult !== 32'd0 || branchResult !== 7'h11 || RdOut !== 7'h05 || OpCode !== 5'd31) begin
      n_fail++;
      $display("FAIL reserved: res=%h flags=%h rd=%h op=%h want 0/11/05/1f",
               AluResult, branchResult, RdOut, OpCode);
    end
    drive_op(5'd2, 32'h0000_0042, 32'd100, 32'hFFFF_FFFF, 32'hx);
    n_checks++;
    if (AluResult !== 32'd99 || RdOut !== 7'h42 || OpCode !== 5'd2) begin
      n_fail++; $display("FAIL addi_xrt: res=%h rd=%h op=%h want 63/42/02", AluResult, RdOut, OpCode);
    end
    drive_op(5'd0, 32'h0000_0013, 32'd100, 32'd5, 32'hx);
    n_checks++;
    if (AluResult !== 32'd0 || RdOut !== 7'h13 || OpCode !== 5'd0) begin
      n_fail++; $display("FAIL nop_xrt: res=%h rd=%h op=%h want 0/13/00", AluResult, RdOut, OpCode);
    end
  endtask

  initial begin
    rst = 1'b1;
    OPCODE = 5'd0; Rd = 32'd0; Rs = 32'd0; Rsi = 32'd0; Rt = 32'd0;
    #2;
    n_checks++;
    if (AluResult !== 32'd0 || branchResult !== 7'd0 || RdOut !== 7'd0 || OpCode !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_initial: res=%h flags=%h rd=%h op=%h want all 0",
               AluResult, branchResult, RdOut, OpCode);
    end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_arith();
    test_logic();
    test_overflow_shift();
    test_branch();
    test_back_to_back();
    test_reserved_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
